// File: rtl/instruction_loader.sv
// Boot loader: assembles 19-bit instruction words from a byte stream and writes them to imem from address 0.
// Optional trailing XOR checksum byte is enabled with the LOADER_CHECKSUM_EN macro.
module instruction_loader #(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   core_hold,
  output logic                   done,
  output logic                   error,
  output logic [3:0]             dbg_state
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; the
  // source holds in_data stable until then, and the loader never drops or repeats a byte.
  typedef enum logic [3:0] {
    S_HDR_LO, S_HDR_HI, S_B0, S_B1, S_B2, S_WR, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t                 state, state_nx;
  logic [7:0]             count_lo;
  logic [11:0]            words_left;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [INSTR_WIDTH-1:0] word;
  logic                   accept;
  logic [11:0]            hdr_count;
  state_t                 end_state;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign end_state = S_CHK;
`else
  assign end_state = S_DONE;
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_count = {in_data[3:0], count_lo};

  always_comb begin
    state_nx = state;
    case (state)
      S_HDR_LO: if (accept) state_nx = S_HDR_HI;
      S_HDR_HI: if (accept) state_nx = (hdr_count == 12'd0) ? end_state : S_B0;
      S_B0:     if (accept) state_nx = S_B1;
      S_B1:     if (accept) state_nx = S_B2;
      // A nonzero pad in the top byte means the stream is malformed; drop the word.
      S_B2:     if (accept) state_nx = (in_data[7:3] != 5'd0) ? S_ERR : S_WR;
      S_WR:     state_nx = (words_left == 12'd1) ? end_state : S_B0;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:    if (accept) state_nx = (in_data == csum) ? S_DONE : S_ERR;
`else
      S_CHK:    state_nx = S_ERR;
`endif
      S_DONE:   state_nx = S_DONE;
      S_ERR:    state_nx = S_ERR;
      default:  state_nx = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HDR_LO;
      count_lo   <= 8'd0;
      words_left <= 12'd0;
      addr       <= '0;
      word       <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        case (state)
          S_HDR_LO: count_lo    <= in_data;
          S_HDR_HI: words_left  <= hdr_count;
          S_B0:     word[7:0]   <= in_data;
          S_B1:     word[15:8]  <= in_data;
          S_B2:     word[18:16] <= in_data[2:0];
          default:  ;
        endcase
      end
      if (state == S_WR) begin
        addr       <= addr + ADDR_WIDTH'(1);
        words_left <= words_left - 12'd1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)         csum <= 8'd0;
    else if (accept) csum <= csum ^ in_data;
  end
`endif

  assign in_ready  = !rst && (state == S_HDR_LO || state == S_HDR_HI || state == S_B0 ||
                              state == S_B1 || state == S_B2 || state == S_CHK);
  assign imem_we    = (state == S_WR);
  assign imem_addr  = addr;
  assign imem_wdata = word;
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);
  assign core_hold  = (state != S_DONE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized scoreboard bench for instruction_loader; a stream-level reference model
// predicts the writes and final outcome, and a monitor checks every imem write.
module tb_instruction_loader;
  localparam int AW = 12;
  localparam int IW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          core_hold;
  logic          done;
  logic          error;
  logic [3:0]    dbg_state;

  instruction_loader #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [AW+IW-1:0] exp_q[$];
  logic [7:0]       stream_q[$];
  int  exp_len;
  bit  exp_done, exp_err;
  int  exp_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b0 && imem_we === 1'b1) begin
      logic [AW+IW-1:0] e;
      chk("ready_in_wr", {31'd0, in_ready}, 32'd0);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=0x%0h data=0x%0h required=none", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (imem_addr !== e[AW+IW-1:IW] || imem_wdata !== e[IW-1:0]) begin
          failures++;
          $display("FAIL write actual=%0h:%0h required=%0h:%0h", imem_addr, imem_wdata,
                   e[AW+IW-1:IW], e[IW-1:0]);
        end
      end
    end
  end

  // Reference model: walks the byte stream by the format rules.
  task automatic model();
    int n, pos;
    logic [7:0] x;
    n   = {stream_q[1][3:0], stream_q[0]};
    x   = stream_q[0] ^ stream_q[1];
    pos = 2;
    for (int w = 0; w < n; w++) begin
      logic [7:0] b0, b1, b2;
      b0 = stream_q[pos]; b1 = stream_q[pos+1]; b2 = stream_q[pos+2];
      x  = x ^ b0 ^ b1 ^ b2;
      if (b2[7:3] != 5'd0) begin
        exp_len = pos + 3; exp_done = 0; exp_err = 1; exp_lat = 1;
        return;
      end
      exp_q.push_back({AW'(w), b2[2:0], b1, b0});
      pos += 3;
    end
`ifdef LOADER_CHECKSUM_EN
    exp_len  = pos + 1;
    exp_done = (stream_q[pos] == x);
    exp_err  = !exp_done;
    exp_lat  = 1;
`else
    exp_len  = pos;
    exp_done = 1;
    exp_err  = 0;
    exp_lat  = (n == 0) ? 1 : 2;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    @(negedge clk);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we",       {31'd0, imem_we}, 32'd0);
    chk("rst_addr",     32'(imem_addr), 32'd0);
    chk("rst_wdata",    32'(imem_wdata), 32'd0);
    chk("rst_done",     {31'd0, done}, 32'd0);
    chk("rst_error",    {31'd0, error}, 32'd0);
    chk("rst_hold",     {31'd0, core_hold}, 32'd1);
    in_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_stream(input int max_gap);
    model();
    for (int i = 0; i < exp_len; i++) send_byte(stream_q[i], $urandom_range(0, max_gap));
    for (int i = 1; i < exp_lat; i++) begin
      @(negedge clk);
      chk("done_early", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    chk("end_done",  {31'd0, done}, {31'd0, exp_done});
    chk("end_error", {31'd0, error}, {31'd0, exp_err});
    chk("end_hold",  {31'd0, core_hold}, {31'd0, !exp_done});
    chk("end_ready", {31'd0, in_ready}, 32'd0);
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    chk("sticky_done",  {31'd0, done}, {31'd0, exp_done});
    chk("sticky_error", {31'd0, error}, {31'd0, exp_err});
  endtask

  task automatic set_first(input logic [7:0] cs);
    stream_q.delete();
    stream_q.push_back(8'h02); stream_q.push_back(8'h00);
    stream_q.push_back(8'h45); stream_q.push_back(8'h23); stream_q.push_back(8'h01);
    stream_q.push_back(8'hFF); stream_q.push_back(8'hFF); stream_q.push_back(8'h07);
    stream_q.push_back(cs);
  endtask

  task automatic build_random(input int n, input bit allow_bad);
    logic [7:0] x, b;
    int bad;
    bad = (allow_bad && n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
    stream_q.delete();
    stream_q.push_back(n[7:0]);
    b = {4'($urandom_range(0, 15)), n[11:8]};
    stream_q.push_back(b);
    x = n[7:0] ^ b;
    for (int w = 0; w < n; w++) begin
      logic [IW-1:0] wd;
      wd = IW'($urandom);
      stream_q.push_back(wd[7:0]);
      stream_q.push_back(wd[15:8]);
      b = {5'd0, wd[18:16]};
      if (w == bad) b[7:3] = 5'($urandom_range(1, 31));
      stream_q.push_back(b);
      x = x ^ wd[7:0] ^ wd[15:8] ^ b;
    end
    if (allow_bad && $urandom_range(0, 4) == 0) x = x ^ 8'($urandom_range(1, 255));
    stream_q.push_back(x);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    do_reset();
    set_first(8'h62); run_stream(0);
    do_reset();
    set_first(8'h62); run_stream(5);
    do_reset();
    stream_q.delete();
    stream_q.push_back(8'h01); stream_q.push_back(8'h00);
    stream_q.push_back(8'h00); stream_q.push_back(8'h00); stream_q.push_back(8'h08);
    stream_q.push_back(8'h09);
    run_stream(0);
    do_reset();
    stream_q.delete();
    stream_q.push_back(8'h00); stream_q.push_back(8'h00); stream_q.push_back(8'h00);
    run_stream(0);
`ifdef LOADER_CHECKSUM_EN
    do_reset();
    set_first(8'h63); run_stream(1);
`endif
    do_reset();
    set_first(8'h62);
    for (int i = 0; i < 4; i++) send_byte(stream_q[i], 0);
    do_reset();
    run_stream(2);
    for (int t = 0; t < 20; t++) begin
      do_reset();
      build_random($urandom_range(0, 6), 1'b1);
      run_stream(5);
    end
    do_reset();
    build_random(257, 1'b0);
    run_stream(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
